// File: rtl/tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
//
// Single-shot, reloadable interval timer used by the Morse symbol receiver to
// time press/release durations. While set_i is high the timer is held in its
// loaded state. Once set_i drops it counts clock ticks and raises a sticky
// expired_o after exactly TICK_COUNT ticks with set_i low. The count saturates
// at TICK_COUNT; only set_i or reset re-arms the timer.
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous reset, ACTIVE HIGH (name inherited)
//   set_i      in   1 = hold/reload (clear count and flag), 0 = run
//   expired_o  out  registered expiry flag, sticky until reload or reset
//   count_o    out  elapsed tick count (CNT_W bits), saturates at TICK_COUNT
// -----------------------------------------------------------------------------
module tick_timer #(
   parameter int TICK_COUNT = 16
) (
   input  logic                                    clk,
   input  logic                                    resetn,
   input  logic                                    set_i,
   output logic                                    expired_o,
   output logic [$clog2(64'(TICK_COUNT) + 64'd1)-1:0] count_o
);

   // Widened to 64 bits so TICK_COUNT = 2^31-1 does not overflow the +1.
   localparam int CNT_W = $clog2(64'(TICK_COUNT) + 64'd1);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TICK_COUNT);

   // A zero or negative interval has no meaningful expiry point.
   if (TICK_COUNT < 1) begin : g_bad_tick_count
      $fatal(1, "tick_timer: TICK_COUNT must be >= 1");
   end

   typedef enum logic {
      ST_ARMED   = 1'b0,
      ST_EXPIRED = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next-state logic: reload beats counting; the count stops at TC_VAL.
   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      if (set_i) begin
         cnt_d   = {CNT_W{1'b0}};
         state_d = ST_ARMED;
      end else if (cnt_q != TC_VAL) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = ((cnt_q + CNT_W'(1)) == TC_VAL) ? ST_EXPIRED : ST_ARMED;
      end else begin
         // Saturated: hold count, stay expired (no wrap, no re-trigger).
         cnt_d   = cnt_q;
         state_d = ST_EXPIRED;
      end
   end

   // State and counter registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         cnt_q   <= {CNT_W{1'b0}};
         state_q <= ST_ARMED;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign expired_o = (state_q == ST_EXPIRED);
   assign count_o   = cnt_q;

endmodule

// File: tb/tb_tick_timer.sv
// -----------------------------------------------------------------------------
// tb_tick_timer
//
// Drives three tick_timer instances (TICK_COUNT = 5, 1, 1000) from a shared
// clock with independent set/reset inputs. Expected outputs come from a model
// that tracks only "consecutive low-set edges since the last reload/reset":
// count = min(run, TICK_COUNT), expired = (run >= TICK_COUNT).
// -----------------------------------------------------------------------------
module tb_tick_timer;

   localparam int N_DUT = 3;
   localparam int TC [N_DUT] = '{5, 1, 1000};

   logic       clk;
   logic       rst_s [N_DUT];
   logic       set_s [N_DUT];
   logic       exp_s [N_DUT];
   logic [2:0] count5_s;
   logic [0:0] count1_s;
   logic [9:0] count1000_s;

   int run_len [N_DUT];
   int n_cmp;
   int n_bad;

   tick_timer #(.TICK_COUNT(5)) u_dut5 (
      .clk       (clk),
      .resetn    (rst_s[0]),
      .set_i     (set_s[0]),
      .expired_o (exp_s[0]),
      .count_o   (count5_s)
   );

   tick_timer #(.TICK_COUNT(1)) u_dut1 (
      .clk       (clk),
      .resetn    (rst_s[1]),
      .set_i     (set_s[1]),
      .expired_o (exp_s[1]),
      .count_o   (count1_s)
   );

   tick_timer #(.TICK_COUNT(1000)) u_dut1000 (
      .clk       (clk),
      .resetn    (rst_s[2]),
      .set_i     (set_s[2]),
      .expired_o (exp_s[2]),
      .count_o   (count1000_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int dut_count(input int i);
      case (i)
         0:       return int'(count5_s);
         1:       return int'(count1_s);
         default: return int'(count1000_s);
      endcase
   endfunction

   task automatic check_all(input string where);
      for (int i = 0; i < N_DUT; i++) begin
         int exp_cnt;
         exp_cnt = (run_len[i] < TC[i]) ? run_len[i] : TC[i];
         check_val($sformatf("%s.cnt[TC=%0d]", where, TC[i]), dut_count(i), exp_cnt);
         check_val($sformatf("%s.exp[TC=%0d]", where, TC[i]), int'(exp_s[i]),
                   (run_len[i] >= TC[i]) ? 1 : 0);
      end
   endtask

   // One clock edge: update the model from the inputs held over the edge,
   // then check away from the edge.
   task automatic tick(input string where);
      @(posedge clk);
      for (int i = 0; i < N_DUT; i++) begin
         if (rst_s[i] || set_s[i]) run_len[i] = 0;
         else if (run_len[i] < TC[i]) run_len[i]++;
      end
      #1;
      check_all(where);
   endtask

   task automatic drive_all(input logic set_v, input int n, input string where);
      for (int i = 0; i < N_DUT; i++) set_s[i] = set_v;
      for (int k = 0; k < n; k++) tick(where);
   endtask

   task automatic async_reset_all(input string where);
      for (int i = 0; i < N_DUT; i++) begin
         rst_s[i]   = 1'b1;
         run_len[i] = 0;
      end
      #1;
      check_all(where);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < N_DUT; i++) begin
         rst_s[i]   = 1'b1;
         set_s[i]   = 1'b0;
         run_len[i] = 0;
      end

      // Reset held: outputs stay 0 even with set low and clock running.
      drive_all(1'b0, 3, "rst_hold");
      #1;
      for (int i = 0; i < N_DUT; i++) rst_s[i] = 1'b0;

      // 1: hold set high after release.
      drive_all(1'b1, 3, "t1_hold");
      // 2: count up to expiry, then stay saturated and sticky.
      drive_all(1'b0, 25, "t2_run");
      // 4: re-arm from expired, then expire again.
      drive_all(1'b1, 1, "t4_rearm");
      drive_all(1'b0, 6, "t4_run");
      // 3: mid-count reload discards the partial count.
      drive_all(1'b1, 1, "t3_load");
      drive_all(1'b0, 3, "t3_part");
      drive_all(1'b1, 1, "t3_reload");
      drive_all(1'b0, 6, "t3_run");
      // 5: asynchronous reset mid-count, release with set low.
      drive_all(1'b1, 1, "t5_load");
      drive_all(1'b0, 3, "t5_part");
      async_reset_all("t5_async");
      tick("t5_rst_edge");
      #1;
      for (int i = 0; i < N_DUT; i++) rst_s[i] = 1'b0;
      drive_all(1'b0, 6, "t5_run");
      // 6: long interval for TC=1000 (and TC=1 saturation).
      drive_all(1'b1, 1, "t6_load");
      drive_all(1'b0, 1005, "t6_run");

      // Randomized phase: independent set and occasional mid-cycle reset.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N_DUT; i++) begin
            if (rst_s[i]) begin
               if ($urandom_range(0, 3) == 0) rst_s[i] = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
               rst_s[i]   = 1'b1;
               run_len[i] = 0;
            end
            set_s[i] = ($urandom_range(0, 11) == 0);
         end
         #1;
         check_all("rnd_mid");
         tick("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
